// File: rtl/ahb_traffic_gen.sv
// ahb_traffic_gen: AHB-Lite master that issues incrementing-burst write,
// read, or write-then-read-check traffic and reports read mismatches.
//
// Build option: define ATG_CHECK_EN to compile in read-data comparison,
// the mismatch counter and mismatch-driven fail. Without it reads are
// issued but never compared, err_cnt stays 0, and fail/first_err_addr
// report only ERROR responses.
module ahb_traffic_gen #(
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    parameter  int MAX_BEATS = 16,
    localparam int CW        = $clog2(MAX_BEATS) + 1
) (
    input  logic              hclk,
    input  logic              hresetn,

    // Run control
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CW-1:0]     num_beats,
    input  logic [DATA_W-1:0] pattern,

    // AHB-Lite master side
    output logic              hsel,
    output logic              hwrite,
    output logic              hready,
    output logic [1:0]        htrans,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [ADDR_W-1:0] haddr,
    output logic [DATA_W-1:0] hwdata,

    // Slave response
    input  logic              hready_resp,
    input  logic [1:0]        hresp,
    input  logic [DATA_W-1:0] hrdata,

    // Status
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [CW-1:0]     err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam logic [1:0]        HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]        HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0]        HTRANS_SEQ    = 2'b11;
    localparam logic [1:0]        HRESP_ERROR   = 2'b01;
    localparam logic [2:0]        HBURST_INCR   = 3'b001;
    localparam logic [2:0]        HSIZE_VAL     = (DATA_W == 8)  ? 3'd0 :
                                                  (DATA_W == 16) ? 3'd1 : 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_STEP     = ADDR_W'(DATA_W / 8);
    // Bits that index within a 1 KB page; a narrow bus only has "wrap to 0".
    localparam int                PAGE_BITS     = (ADDR_W < 10) ? ADDR_W : 10;
    localparam logic [CW-1:0]     MAX_N         = CW'(MAX_BEATS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WDRAIN,
        ST_RD,
        ST_RDRAIN,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t            state;
    logic              mode_chk;     // write pass is followed by a read-check pass
    logic [CW-1:0]     n_beats_r;
    logic [ADDR_W-1:0] base_r;
    logic [DATA_W-1:0] pattern_r;
    logic [CW-1:0]     a_idx;        // beat index of the current address phase
    logic [DATA_W-1:0] a_data;       // pattern + a_idx, the beat's data value
    logic              err_seen;     // first_err_addr already captured this run

    // Transfer currently in its data phase
    logic              dp_valid;
    logic [ADDR_W-1:0] dp_addr;

    logic [ADDR_W-1:0] next_addr;
    logic              next_nonseq;
    logic              last_addr;
    logic              bus_err;
    logic              rd_mismatch;

    assign hready      = hready_resp;
    assign next_addr   = haddr + ADDR_STEP;
    // A beat that lands on a page start (or wraps to 0) must restart the burst.
    assign next_nonseq = (next_addr[PAGE_BITS-1:0] == '0);
    assign last_addr   = (a_idx == n_beats_r - CW'(1));
    assign bus_err     = (state == ST_WR || state == ST_WDRAIN ||
                          state == ST_RD || state == ST_RDRAIN) &&
                         hready_resp && (hresp == HRESP_ERROR);

    // Track which transfer owns the data phase, advancing only on accepted cycles
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dp_valid <= 1'b0;
            dp_addr  <= '0;
        end else if (hready_resp) begin
            // NOTE: non-blocking so every register here and in the FSM sees pre-edge values.
            dp_valid <= (state == ST_WR || state == ST_RD) && !bus_err;
            dp_addr  <= haddr;
        end
    end

`ifdef ATG_CHECK_EN
    logic              dp_rd;
    logic [DATA_W-1:0] dp_exp;

    // Remember the expected word for the read currently in its data phase
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dp_rd  <= 1'b0;
            dp_exp <= '0;
        end else if (hready_resp) begin
            dp_rd  <= (state == ST_RD) && !bus_err;
            dp_exp <= a_data;
        end
    end

    assign rd_mismatch = dp_rd && hready_resp && (hrdata != dp_exp);
`else
    logic unused_rdata;

    assign unused_rdata = ^hrdata;
    assign rd_mismatch  = 1'b0;
`endif

    // Run sequencer: address phases, write data, status and completion
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state          <= ST_IDLE;
            mode_chk       <= 1'b0;
            n_beats_r      <= '0;
            base_r         <= '0;
            pattern_r      <= '0;
            a_idx          <= '0;
            a_data         <= '0;
            err_seen       <= 1'b0;
            hsel           <= 1'b0;
            hwrite         <= 1'b0;
            htrans         <= HTRANS_IDLE;
            hsize          <= 3'd0;
            hburst         <= 3'd0;
            haddr          <= '0;
            hwdata         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            fail           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            done <= 1'b0;

            if (bus_err) begin
                // Abandon the burst: park the bus and report once
                state  <= ST_ERR;
                hsel   <= 1'b0;
                hwrite <= 1'b0;
                htrans <= HTRANS_IDLE;
                fail   <= 1'b1;
                done   <= 1'b1;
                if (!err_seen) begin
                    first_err_addr <= dp_valid ? dp_addr : haddr;
                    err_seen       <= 1'b1;
                end
            end else begin
                if (rd_mismatch) begin
                    err_cnt <= err_cnt + CW'(1);
                    fail    <= 1'b1;
                    if (!err_seen) begin
                        first_err_addr <= dp_addr;
                        err_seen       <= 1'b1;
                    end
                end

                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            busy           <= 1'b1;
                            fail           <= 1'b0;
                            err_cnt        <= '0;
                            first_err_addr <= '0;
                            err_seen       <= 1'b0;
                            mode_chk       <= (mode == 2'b10);
                            n_beats_r      <= (num_beats > MAX_N) ? MAX_N : num_beats;
                            base_r         <= base_addr;
                            pattern_r      <= pattern;
                            hsize          <= HSIZE_VAL;
                            hburst         <= HBURST_INCR;
                            if (num_beats == '0) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                state  <= (mode == 2'b01) ? ST_RD : ST_WR;
                                hsel   <= 1'b1;
                                hwrite <= (mode != 2'b01);
                                htrans <= HTRANS_NONSEQ;
                                haddr  <= base_addr;
                                a_idx  <= '0;
                                a_data <= pattern;
                            end
                        end
                    end

                    ST_WR, ST_RD: begin
                        if (hready_resp) begin
                            // Accepted address becomes next cycle's data phase
                            if (state == ST_WR) begin
                                hwdata <= a_data;
                            end
                            if (last_addr) begin
                                state  <= (state == ST_WR) ? ST_WDRAIN : ST_RDRAIN;
                                hsel   <= 1'b0;
                                hwrite <= 1'b0;
                                htrans <= HTRANS_IDLE;
                            end else begin
                                a_idx  <= a_idx + CW'(1);
                                a_data <= a_data + DATA_W'(1);
                                haddr  <= next_addr;
                                htrans <= next_nonseq ? HTRANS_NONSEQ : HTRANS_SEQ;
                            end
                        end
                    end

                    ST_WDRAIN: begin
                        if (hready_resp) begin
                            if (mode_chk) begin
                                state  <= ST_RD;
                                hsel   <= 1'b1;
                                hwrite <= 1'b0;
                                htrans <= HTRANS_NONSEQ;
                                haddr  <= base_r;
                                a_idx  <= '0;
                                a_data <= pattern_r;
                            end else begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end
                        end
                    end

                    ST_RDRAIN: begin
                        if (hready_resp) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end

                    ST_DONE, ST_ERR: begin
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        hsize  <= 3'd0;
                        hburst <= 3'd0;
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ahb_traffic_gen.sv
// Directed bench for ahb_traffic_gen with a small behavioural SRAM slave
// that can insert wait states, ERROR responses and corrupted read words.
module tb_ahb_traffic_gen;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 5;

    logic          hclk      = 1'b0;
    logic          hresetn   = 1'b0;
    logic          start     = 1'b0;
    logic [1:0]    mode      = 2'b00;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] num_beats = '0;
    logic [DW-1:0] pattern   = '0;

    logic          hsel, hwrite, hready;
    logic [1:0]    htrans;
    logic [2:0]    hsize, hburst;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hwdata;
    logic          hready_resp;
    logic [1:0]    hresp;
    logic [DW-1:0] hrdata;
    logic          busy, done, fail;
    logic [CW-1:0] err_cnt;
    logic [AW-1:0] first_err_addr;

    ahb_traffic_gen #(.ADDR_W(AW), .DATA_W(DW), .MAX_BEATS(16)) dut (
        .hclk           (hclk),
        .hresetn        (hresetn),
        .start          (start),
        .mode           (mode),
        .base_addr      (base_addr),
        .num_beats      (num_beats),
        .pattern        (pattern),
        .hsel           (hsel),
        .hwrite         (hwrite),
        .hready         (hready),
        .htrans         (htrans),
        .hsize          (hsize),
        .hburst         (hburst),
        .haddr          (haddr),
        .hwdata         (hwdata),
        .hready_resp    (hready_resp),
        .hresp          (hresp),
        .hrdata         (hrdata),
        .busy           (busy),
        .done           (done),
        .fail           (fail),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr)
    );

    always #5 hclk = ~hclk;

    int cyc = 0;
    always @(posedge hclk) cyc <= cyc + 1;

    // ---------------- slave model ----------------
    logic [31:0] mem [0:1023];
    logic        dph_valid, dph_write;
    logic [31:0] dph_addr;
    int          stall_cnt;
    logic [31:0] stall_addr   = '1;
    logic [31:0] err_addr     = '1;
    logic [31:0] corrupt_addr = '1;

    assign hready_resp = (stall_cnt == 0);
    assign hresp  = (hready_resp && dph_valid && dph_write && dph_addr == err_addr) ? 2'b01 : 2'b00;
    assign hrdata = mem[dph_addr[11:2]] ^ ((dph_addr == corrupt_addr) ? 32'h1 : 32'h0);

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dph_valid <= 1'b0;
            dph_write <= 1'b0;
            dph_addr  <= '0;
            stall_cnt <= 0;
        end else begin
            if (stall_cnt > 0)
                stall_cnt <= stall_cnt - 1;
            else if (hsel && htrans[1] && hwrite && haddr == stall_addr)
                stall_cnt <= 3;
            if (hready_resp) begin
                if (dph_valid && dph_write)
                    mem[dph_addr[11:2]] <= hwdata;
                dph_valid <= hsel && htrans[1];
                dph_write <= hwrite;
                dph_addr  <= haddr;
            end
        end
    end

    // ---------------- bus monitor ----------------
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
    } aph_t;

    aph_t        aph_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] rd_q[$];

    always @(negedge hclk) begin
        if (hresetn && hready_resp) begin
            if (hsel && htrans[1])
                aph_q.push_back({haddr, htrans, hwrite});
            if (dph_valid && dph_write)
                wd_q.push_back(hwdata);
            if (dph_valid && !dph_write)
                rd_q.push_back(hrdata);
        end
    end

    // ---------------- checking helpers ----------------
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int t0      = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge; returns at the first cycle of the run (offset 1).
    task automatic launch(input logic [1:0] m, input logic [31:0] b,
                          input logic [CW-1:0] n, input logic [31:0] p);
        mode      = m;
        base_addr = b;
        num_beats = n;
        pattern   = p;
        start     = 1'b1;
        @(negedge hclk);
        start     = 1'b0;
        t0        = cyc;
    endtask

    task automatic wait_done(input string tag, output int offs);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 300) begin
            @(negedge hclk);
            k++;
        end
        check({tag, "_done_seen"}, done, 1);
        offs = cyc - t0 + 1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   offs, k, a0, w0, r0;
        logic saw_done;
        aph_t e;

        // Reset state
        #12;
        check("rst_ctrl", {busy, done, fail, hsel, hwrite, htrans, hsize, hburst}, 0);
        check("rst_haddr", haddr, 0);
        check("rst_hwdata", hwdata, 0);
        check("rst_err", {err_cnt, first_err_addr}, 0);
        @(negedge hclk);
        hresetn = 1'b1;
        @(negedge hclk);

        // T1: check mode, single beat
        a0 = aph_q.size(); w0 = wd_q.size(); r0 = rd_q.size();
        launch(2'b10, 32'h50, 5'd1, 32'hA0B0C0D0);
        check("t1_haddr", haddr, 32'h50);
        check("t1_htrans", htrans, 2'b10);
        check("t1_ctrl", {hsel, hwrite, busy, done, hsize, hburst}, {4'b1110, 3'd2, 3'd1});
        wait_done("t1", offs);
        check("t1_latency", offs, 5);
        check("t1_status", {fail, err_cnt}, 0);
        check("t1_wdata", wd_q[w0], 32'hA0B0C0D0);
        check("t1_rdata", rd_q[r0], 32'hA0B0C0D0);
        check("t1_aph_cnt", aph_q.size() - a0, 2);
        @(negedge hclk);
        check("t1_idle", {busy, done, hsize, hburst}, 0);

        // T2: check mode, 16 beats from 0xF010
        a0 = aph_q.size(); w0 = wd_q.size(); r0 = rd_q.size();
        launch(2'b10, 32'hF010, 5'd16, 32'h0A0B0C0D);
        wait_done("t2", offs);
        check("t2_latency", offs, 35);
        check("t2_status", {fail, err_cnt}, 0);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 16; i++) begin
                e = aph_q[a0 + p * 16 + i];
                check($sformatf("t2_aph_p%0d_b%0d", p, i), e,
                      {32'hF010 + 32'(4 * i), (i == 0) ? 2'b10 : 2'b11, p == 0});
            end
        end
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t2_wdata_b%0d", i), wd_q[w0 + i], 32'h0A0B0C0D + 32'(i));
            check($sformatf("t2_rdata_b%0d", i), rd_q[r0 + i], 32'h0A0B0C0D + 32'(i));
        end
        @(negedge hclk);

        // T3: write-only across the 0x400 page boundary
        a0 = aph_q.size(); w0 = wd_q.size();
        launch(2'b00, 32'h3F8, 5'd4, 32'h11111111);
        wait_done("t3", offs);
        check("t3_latency", offs, 6);
        check("t3_aph0", aph_q[a0 + 0], {32'h3F8, 2'b10, 1'b1});
        check("t3_aph1", aph_q[a0 + 1], {32'h3FC, 2'b11, 1'b1});
        check("t3_aph2", aph_q[a0 + 2], {32'h400, 2'b10, 1'b1});
        check("t3_aph3", aph_q[a0 + 3], {32'h404, 2'b11, 1'b1});
        check("t3_wdata3", wd_q[w0 + 3], 32'h11111114);
        check("t3_aph_cnt", aph_q.size() - a0, 4);
        @(negedge hclk);

        // T4: check mode, 8 beats, 3 wait states on write beat 3
        w0 = wd_q.size();
        stall_addr = 32'h20C;
        launch(2'b10, 32'h200, 5'd8, 32'h5000);
        k = 0;
        while (hready_resp === 1'b1 && k < 20) begin
            @(negedge hclk);
            k++;
        end
        check("t4_stall_start", k, 4);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("t4_hold%0d", s), {haddr, hwdata}, {32'h210, 32'h5003});
            check($sformatf("t4_hready%0d", s), {hready, htrans}, {1'b0, 2'b11});
            @(negedge hclk);
        end
        wait_done("t4", offs);
        stall_addr = '1;
        check("t4_latency", offs, 22);
        check("t4_status", {fail, err_cnt}, 0);
        for (int i = 0; i < 8; i++)
            check($sformatf("t4_wdata_b%0d", i), wd_q[w0 + i], 32'h5000 + 32'(i));
        @(negedge hclk);

        // T5: fill 0x100.., then read-only with beat 5 corrupted
        launch(2'b00, 32'h100, 5'd8, 32'hC0000000);
        wait_done("t5w", offs);
        check("t5w_latency", offs, 10);
        @(negedge hclk);
        a0 = aph_q.size();
        corrupt_addr = 32'h114;
        launch(2'b01, 32'h100, 5'd8, 32'hC0000000);
        check("t5_first_aph", {haddr, htrans, hwrite, hsel}, {32'h100, 2'b10, 1'b0, 1'b1});
        wait_done("t5", offs);
        check("t5_latency", offs, 10);
`ifdef ATG_CHECK_EN
        check("t5_err_cnt", err_cnt, 1);
        check("t5_fail", fail, 1);
        check("t5_first_err", first_err_addr, 32'h114);
`else
        check("t5_err_cnt", err_cnt, 0);
        check("t5_fail", fail, 0);
        check("t5_first_err", first_err_addr, 0);
`endif
        check("t5_aph_cnt", aph_q.size() - a0, 8);
        corrupt_addr = '1;
        @(negedge hclk);

        // T6: zero beats goes straight to done with no bus activity
        a0 = aph_q.size();
        launch(2'b00, 32'h80, 5'd0, 32'h1);
        check("t6_htrans", {hsel, htrans}, 0);
        wait_done("t6", offs);
        check("t6_latency", offs, 1);
        @(negedge hclk);
        check("t6_aph_cnt", aph_q.size() - a0, 0);
        check("t6_idle", {busy, done}, 0);

        // T7: ERROR response on write beat 2
        err_addr = 32'h608;
        launch(2'b00, 32'h600, 5'd6, 32'h77);
        k = 0;
        while (hresp !== 2'b01 && k < 20) begin
            @(negedge hclk);
            k++;
        end
        check("t7_err_cycle", k, 3);
        @(negedge hclk);
        check("t7_err_htrans", htrans, 2'b00);
        check("t7_err_flags", {done, fail, busy, hsel}, 4'b1110);
        check("t7_first_err", first_err_addr, 32'h608);
        @(negedge hclk);
        check("t7_after", {done, busy, fail}, 3'b001);
        err_addr = '1;

        // T8: asynchronous reset in the middle of a run
        launch(2'b10, 32'h700, 5'd8, 32'h1);
        check("t8_fail_cleared", fail, 0);
        repeat (3) @(negedge hclk);
        check("t8_active", {hsel, hwrite, busy}, 3'b111);
        #2;
        hresetn = 1'b0;
        #1;
        check("t8_rst_ctrl", {busy, done, fail, hsel, hwrite, htrans, hsize, hburst}, 0);
        check("t8_rst_bus", {haddr, hwdata}, 0);
        check("t8_rst_err", {err_cnt, first_err_addr}, 0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge hclk);
            saw_done = saw_done | done;
        end
        hresetn = 1'b1;
        repeat (2) begin
            @(negedge hclk);
            saw_done = saw_done | done;
        end
        check("t8_no_done", saw_done, 0);
        check("t8_idle", {busy, htrans, hsel}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ahb_traffic_gen.md
# ahb_traffic_gen

Parametrised, synthesizable AHB-Lite master that generates incrementing-burst write, read, or write-then-read-check traffic toward the `sramc_top` slave port, replacing hand-driven task stimulus for bring-up and soak testing. Software or a wrapper loads a base address, a beat count and a mode, then pulses `start`. The block drives pipelined address and data phases, honours `hready_resp` stalls and `hresp` errors, regenerates the expected pattern on reads, and reports a mismatch count.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; must be 8, 16 or 32.
- `MAX_BEATS`, 16: maximum beats per run; `CW = $clog2(MAX_BEATS)+1`.
- `hclk` input 1: clock.
- `hresetn` input 1: asynchronous active-low reset.
- `start` input 1: one-cycle run request; ignored while `busy`.
- `mode` input 2: 00 write-only, 01 read-only, 10 write-then-read-check, 11 reserved (treated as 00).
- `base_addr` input ADDR_W: first beat address; must be aligned to DATA_W/8.
- `num_beats` input CW: beat count, from 0 to MAX_BEATS.
- `pattern` input DATA_W: seed for beat data.
- `hsel`, `hwrite`, `hready` output 1: AHB controls. `hready` mirrors `hready_resp`.
- `htrans` output 2, `hsize` output 3, `hburst` output 3: AHB controls.
- `haddr` output ADDR_W, `hwdata` output DATA_W: AHB address and write data.
- `hready_resp` input 1, `hresp` input 2, `hrdata` input DATA_W: slave response.
- `busy` output 1: run in progress.
- `done` output 1: one-cycle completion pulse.
- `fail` output 1: sticky until next `start`. Set on `hresp`=ERROR or any read mismatch.
- `err_cnt` output CW: read mismatches in the last run.
- `first_err_addr` output ADDR_W: address of the first mismatch or ERROR.

## Operation
- Reset: every output is 0 and `htrans`=IDLE. `hsize`/`hburst` read 0. Reset mid-run abandons the run immediately with no `done`.
- States:
  - `IDLE` -> `WR` on `start` (modes 00, 10).
  - `IDLE` -> `RD` on `start` (mode 01).
  - `WR` -> `WDRAIN` after the last address phase is accepted.
  - `WDRAIN` -> `RD` (mode 10) or `DONE` when the last data phase completes.
  - `RD` -> `RDRAIN` -> `DONE`.
  - `DONE` pulses `done` for one cycle -> `IDLE`.
  - Any state except `IDLE` -> `ERR` on `hresp`=01 with `hready_resp`=1. `ERR` drives `htrans`=IDLE, sets `fail`, pulses `done` -> `IDLE`.
- `num_beats`=0: `start` goes straight to `DONE`. No bus activity.
- Beat i address is `base_addr + i*(DATA_W/8)`, wrapping modulo 2^ADDR_W.
- Beat i data is `pattern + i`, modulo 2^DATA_W. Read checks compare against the same value.
- `hsize` = log2(DATA_W/8). `hburst`=INCR (001).
- `htrans` is NONSEQ on the first beat of each pass and SEQ on following beats.
  - A beat whose address crosses a 1 KB boundary or wraps the address space is issued as NONSEQ.
- `hsel`=1 and `hwrite`=1/0 during address phases of `WR` and `RD`.
- Stall: while `hready_resp`=0, `haddr`, controls and `hwdata` hold, and no beat index advances.
- `hwdata` for beat i is driven in the data phase, the cycle after beat i's address phase is accepted.
- `hrdata` is sampled only when `hready_resp`=1 in a read data phase.
- `start` is accepted only in `IDLE`. Accepting it clears `fail`, `err_cnt` and `first_err_addr`.

## Timing
- `start` sampled high at edge T. First address phase at T+1.
- Zero-wait write of N beats:
  - Address phases T+1..T+N.
  - Data phases T+2..T+N+1.
  - `done` at T+N+2.
- Zero-wait check mode:
  - Read address phases T+N+2..T+2N+1.
  - `hrdata` samples at T+N+3..T+2N+2.
  - `done` at T+2N+3.
- Read-only: `done` at T+N+2.
- Each wait cycle (`hready_resp`=0) adds exactly one cycle.
- `busy` is high from T+1 through the `done` cycle inclusive.
- `err_cnt` and `first_err_addr` are valid when `done` is high.

## Configuration
- `ATG_CHECK_EN` defined: read data comparison, `err_cnt` and mismatch-driven `fail` are compiled in.
- Without `ATG_CHECK_EN`:
  - Reads are issued but not compared.
  - `err_cnt` is tied to 0.
  - `fail` and `first_err_addr` report only `hresp` ERROR.

## Test plan
- Mode 10, base 0x50, N=1, pattern 0xA0B0C0D0, zero-wait -> write beat, then read returns 0xA0B0C0D0. `done` at T+5, `fail`=0, `err_cnt`=0.
- Mode 10, base 0xF010, N=16, pattern 0x0A0B0C0D -> `haddr` steps by 4 with NONSEQ then 15 SEQ per pass. Read data is 0x0A0B0C0D..0x0A0B0C1C, `err_cnt`=0.
- Mode 00, base 0x3F8, N=4 -> beat 2 at 0x400 is NONSEQ, other beats SEQ.
- Mode 10, N=8, slave model holds `hready_resp` low 3 cycles on beat 3 -> address and `hwdata` held constant during the stall, `done` 3 cycles later than zero-wait.
- Mode 01 with slave returning a corrupted word at beat 5 of base 0x100 (`ATG_CHECK_EN`) -> `err_cnt`=1, `first_err_addr`=0x114, `fail`=1.
- `hresp`=ERROR on beat 2 of a write run -> `htrans`=IDLE next cycle, `done` pulse, `fail`=1. Then assert `hresetn` low mid-run in a new run -> all outputs 0 asynchronously, no `done`.
